// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder datapath.
package adder_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic bit widthIsDivisible(int width, int stages);
    return (stages > 0) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple of full-adder cells; one instance per pipeline stage.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  // The carry is kept in a block-local variable so the ripple is one combinational process.
  always_comb begin : p_ripple
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract over STAGES registered carry-chain slices with valid/ready handshake.
// Optional NZCV flag generation is enabled by defining PIPELINED_ADDER_FLAGS_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       flags
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  if (!widthIsDivisible(WIDTH, STAGES)) begin : g_badConfig
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic              w_stall;
  logic [WIDTH-1:0]  w_bEff;
  logic              w_c0;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_acc [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];

  logic [STAGES-1:0] w_vIn;
  logic [STAGES-1:0] w_cIn;
  logic [STAGES-1:0] w_sliceCout;
  logic [WIDTH-1:0]  w_accIn   [STAGES];
  logic [WIDTH-1:0]  w_bIn     [STAGES];
  logic [WIDTH-1:0]  w_accNext [STAGES];
  logic [SLICE-1:0]  w_sliceSum [STAGES];

  assign w_stall   = r_valid[LAST] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_bEff    = sub ? ~b : b;
  assign w_c0      = sub | cin;

  assign out_valid = r_valid[LAST];
  assign sum       = r_acc[LAST];
  assign cout      = r_carry[LAST];

  // r_acc holds finished low slices below the current slice and untouched A bits above it;
  // r_b is shifted down one slice per stage so the next slice always sits at bit 0.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_vIn[k]   = in_valid;
      assign w_cIn[k]   = w_c0;
      assign w_accIn[k] = a;
      assign w_bIn[k]   = w_bEff;
    end else begin : g_body
      assign w_vIn[k]   = r_valid[k-1];
      assign w_cIn[k]   = r_carry[k-1];
      assign w_accIn[k] = r_acc[k-1];
      assign w_bIn[k]   = r_b[k-1];
    end

    adder_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a    (w_accIn[k][k*SLICE +: SLICE]),
      .b    (w_bIn[k][SLICE-1:0]),
      .cin  (w_cIn[k]),
      .sum  (w_sliceSum[k]),
      .cout (w_sliceCout[k])
    );

    assign w_accNext[k] = (w_accIn[k] & ~(SLICE_MASK << (k*SLICE)))
                        | (WIDTH'(w_sliceSum[k]) << (k*SLICE));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_carry <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_acc[k] <= '0;
        r_b[k]   <= '0;
      end
    end else if (!w_stall) begin
      r_valid <= w_vIn;
      r_carry <= w_sliceCout;
      for (int k = 0; k < STAGES; k++) begin
        r_acc[k] <= w_accNext[k];
        r_b[k]   <= w_bIn[k] >> SLICE;
      end
    end
  end

`ifdef PIPELINED_ADDER_FLAGS_EN
  flags_t r_flags;
  flags_t w_flagsNext;
  logic   w_aMsb;
  logic   w_bMsb;

  // Operand MSBs are still present in the skewed stage inputs when the last slice is added.
  assign w_aMsb = w_accIn[LAST][WIDTH-1];
  assign w_bMsb = w_bIn[LAST][SLICE-1];

  always_comb begin
    w_flagsNext   = '0;
    w_flagsNext.n = w_accNext[LAST][WIDTH-1];
    w_flagsNext.z = (w_accNext[LAST] == '0);
    w_flagsNext.c = w_sliceCout[LAST];
    w_flagsNext.v = (w_aMsb == w_bMsb) & (w_accNext[LAST][WIDTH-1] != w_aMsb);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= '0;
    end else if (!w_stall) begin
      r_flags <= w_flagsNext;
    end
  end

  assign flags = r_flags;
`else
  assign flags = 4'b0000;
`endif

endmodule
